// File: rtl/sort_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_sched_pkg
//  Description : Shared types and default constants for the sorter job
//                scheduler: controller state encoding and default sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_sched_pkg;

    // Default number of requesters sharing the sorter
    localparam int unsigned C_NREQ_DEFAULT    = 4;
    // Default watchdog limit, in cycles spent in RUN
    localparam int unsigned C_TIMEOUT_DEFAULT = 4096;

    // Scheduler controller states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        RUN      = 3'd2,
        RELEASE  = 3'd3,
        ABORT    = 3'd4,
        COMPLETE = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the index of the
//                first asserted request found searching upward from the
//                round-robin pointer, wrapping at NREQ-1.
//  Ports       : i_req    [NREQ-1:0] request vector
//                i_rr_ptr [IW-1:0]   index with highest priority this round
//                o_idx    [IW-1:0]   selected requester index
//                o_valid             at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    // Walk offsets from farthest to nearest so the nearest hit (the first one
    // counting up from the pointer) is the last assignment and wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            logic [IW-1:0] w_pos;
            w_pos = IW'((int'(i_rr_ptr) + i) % NREQ);
            if (i_req[w_pos]) begin
                o_idx   = w_pos;
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sort_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sort_job_scheduler
//  Description : Shares one sorter engine between NREQ requesters. A
//                round-robin winner is frozen per job; the job launches the
//                sorter with a start pulse, waits for done, then pulses start
//                again to return the sorter controller to idle. A watchdog
//                aborts a job stuck in RUN by pulsing the sorter reset.
//  Ports       : clk          clock, rising edge
//                rst          synchronous active-high reset
//                req  [N]     level request per requester
//                gnt  [N]     one-hot grant held for the whole job
//                cmpl [N]     one-cycle completion pulse to the winner
//                job_err      with cmpl: the job was aborted
//                sort_start   start pulse to sorter controller
//                sort_done    done level from sorter controller
//                sort_rst     one-cycle sorter reset on abort
//                busy         scheduler not in IDLE
//                err          sticky abort flag, cleared by err_clr
//                err_clr      clears err (an abort the same cycle wins)
//  Revision    : 1.0  initial release
// ============================================================================
module sort_job_scheduler
    import sort_sched_pkg::*;
#(
    parameter int NREQ        = C_NREQ_DEFAULT,
    parameter int TIMEOUT_CYC = C_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] cmpl,
    output logic            job_err,
    output logic            sort_start,
    input  logic            sort_done,
    output logic            sort_rst,
    output logic            busy,
    output logic            err,
    input  logic            err_clr
);

    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT_CYC);

    localparam logic [WW-1:0] c_WD_LAST  = WW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] c_LAST_REQ = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ONE    = NREQ'(1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [IW-1:0] r_winner;
    logic [IW-1:0] r_rr_ptr;
    logic [WW-1:0] r_wd_cnt;
    logic          r_abort;
    logic          r_err;

    logic [IW-1:0]   w_arb_idx;
    logic            w_arb_valid;
    logic [NREQ-1:0] w_win_oh;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_arb_idx),
        .o_valid  (w_arb_valid)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. sort_done is only looked at in RUN, and it takes
    // priority over a watchdog expiry landing on the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (sort_done) begin
                    w_state_nxt = RELEASE;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_state_nxt = ABORT;
                end
            end
            RELEASE:  w_state_nxt = COMPLETE;
            ABORT:    w_state_nxt = COMPLETE;
            COMPLETE: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Job datapath: winner capture, round-robin pointer, watchdog,
    // abort flag and sticky error.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_wd_cnt <= '0;
            r_abort  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_winner <= w_arb_idx;
                    end
                end
                LAUNCH: begin
                    r_wd_cnt <= '0;
                    r_abort  <= 1'b0;
                end
                RUN: begin
                    if (!sort_done && (r_wd_cnt != c_WD_LAST)) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    r_abort <= 1'b1;
                end
                COMPLETE: begin
                    r_rr_ptr <= (r_winner == c_LAST_REQ) ? '0 : r_winner + 1'b1;
                end
                default: ;
            endcase

            // Setting the error in ABORT overrides a simultaneous clear
            if (r_state == ABORT) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from state and the registered winner
    // ------------------------------------------------------------------
    assign w_win_oh = c_ONE << r_winner;

    always_comb begin
        gnt        = '0;
        cmpl       = '0;
        job_err    = 1'b0;
        sort_start = 1'b0;
        sort_rst   = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            LAUNCH: begin
                gnt        = w_win_oh;
                sort_start = 1'b1;
            end
            RUN: begin
                gnt = w_win_oh;
            end
            RELEASE: begin
                gnt        = w_win_oh;
                sort_start = 1'b1;
            end
            ABORT: begin
                gnt      = w_win_oh;
                sort_rst = 1'b1;
            end
            COMPLETE: begin
                gnt     = w_win_oh;
                cmpl    = w_win_oh;
                job_err = r_abort;
            end
            default: ;
        endcase
    end

    assign err = r_err;

endmodule
`default_nettype wire
